// File: rtl/quick_spi_pkg.sv
// quick_spi_pkg: SPI state encoding and frame-length width helper, shared by the SPI controller and responder.
package quick_spi_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_COMPLETE} spi_state_t;
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction
endpackage

// File: rtl/spi_input_sync.sv
// spi_input_sync: multi-stage synchronizer for one asynchronous input.
//   clk_i/rst_i: clock and async active-high reset (flops load RST_VAL)
//   d: asynchronous input, q: synchronized output (STAGES cycles latency, STAGES >= 2)
module spi_input_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) ff <= {STAGES{RST_VAL}};
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/quick_spi_responder.sv
// quick_spi_responder: SPI peripheral (SCLK idles high, sample on rise, shift on fall, active-low CS).
//   clk_i, rst_i            system clock, async active-high reset (deasserted synchronously inside)
//   txdata_*                response word load port (valid/ready), bit 0 sent first
//   rxdata_*                received frame port (valid/ready) with bit count
//   tx_underrun_o           one-cycle pulse when a frame starts with no response word
//   sclk_i, cs_n_i, sdata_i asynchronous SPI pins; sdata_o response data
//   rx_overrun_o            sticky overrun flag, present only with QUICK_SPI_RESPONDER_OVERRUN_EN
module quick_spi_responder import quick_spi_pkg::*; #(
  parameter int   MAX_DATA_LENGTH = 16,
  parameter int   SYNC_STAGES     = 2,
  parameter logic IDLE_SDATA      = 1'b0
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 txdata_valid_i,
  output logic                                 txdata_ready_o,
  input  logic [MAX_DATA_LENGTH-1:0]           txdata_i,
  output logic                                 rxdata_valid_o,
  input  logic                                 rxdata_ready_i,
  output logic [MAX_DATA_LENGTH-1:0]           rxdata_o,
  output logic [len_width(MAX_DATA_LENGTH)-1:0] rxdata_len_o,
  output logic                                 tx_underrun_o,
  input  logic                                 sclk_i,
  input  logic                                 cs_n_i,
  input  logic                                 sdata_i,
  output logic                                 sdata_o
`ifdef QUICK_SPI_RESPONDER_OVERRUN_EN
  ,
  output logic                                 rx_overrun_o
`endif
);
  localparam int LW = len_width(MAX_DATA_LENGTH);
  localparam logic [LW-1:0] MAX_CNT = LW'(MAX_DATA_LENGTH);
  logic rst, sclk_s, cs_n_s, sdata_s, sclk_d, cs_n_d, lead_in;
  logic cs_fall, cs_rise, sclk_rise, sclk_fall, tx_load, have_word;
  logic [MAX_DATA_LENGTH-1:0] tx_buf, tx_sr, rx_sr, tx_next;
  logic [LW-1:0] cnt;
  spi_state_t state;
  // reset asserts immediately but releases in step with clk_i
  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_rst_sync (.clk_i, .rst_i, .d(1'b0), .q(rst));
  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (.clk_i, .rst_i(rst), .d(sclk_i), .q(sclk_s));
  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (.clk_i, .rst_i(rst), .d(cs_n_i), .q(cs_n_s));
  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdata_sync (.clk_i, .rst_i(rst), .d(sdata_i), .q(sdata_s));
  assign cs_fall   = cs_n_d & ~cs_n_s;
  assign cs_rise   = ~cs_n_d & cs_n_s;
  assign sclk_rise = ~sclk_d & sclk_s;
  assign sclk_fall = sclk_d & ~sclk_s;
  assign tx_load   = txdata_valid_i & txdata_ready_o;
  // a word offered in the same cycle as cs_fall is used for this frame
  assign have_word = ~txdata_ready_o | txdata_valid_i;
  assign tx_next   = txdata_ready_o ? txdata_i : tx_buf;
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      sclk_d         <= 1'b1;
      cs_n_d         <= 1'b1;
      lead_in        <= 1'b0;
      tx_buf         <= '0;
      tx_sr          <= {MAX_DATA_LENGTH{IDLE_SDATA}};
      rx_sr          <= '0;
      cnt            <= '0;
      txdata_ready_o <= 1'b1;
      rxdata_valid_o <= 1'b0;
      rxdata_o       <= '0;
      rxdata_len_o   <= '0;
      tx_underrun_o  <= 1'b0;
      sdata_o        <= IDLE_SDATA;
`ifdef QUICK_SPI_RESPONDER_OVERRUN_EN
      rx_overrun_o   <= 1'b0;
`endif
    end else begin
      sclk_d        <= sclk_s;
      cs_n_d        <= cs_n_s;
      tx_underrun_o <= 1'b0;
      if (tx_load) begin
        tx_buf         <= txdata_i;
        txdata_ready_o <= 1'b0;
      end
      if (rxdata_valid_o && rxdata_ready_i) begin
        rxdata_valid_o <= 1'b0;
`ifdef QUICK_SPI_RESPONDER_OVERRUN_EN
        rx_overrun_o   <= 1'b0;
`endif
      end
      case (state)
        ST_IDLE: if (cs_fall) begin
          state          <= ST_ACTIVE;
          cnt            <= '0;
          rx_sr          <= '0;
          lead_in        <= 1'b1;
          txdata_ready_o <= 1'b1;
          tx_sr          <= have_word ? tx_next : {MAX_DATA_LENGTH{IDLE_SDATA}};
          sdata_o        <= have_word ? tx_next[0] : IDLE_SDATA;
          tx_underrun_o  <= ~have_word;
        end
        ST_ACTIVE: begin
          if (sclk_rise && cnt != MAX_CNT) begin
            rx_sr <= {rx_sr[MAX_DATA_LENGTH-2:0], sdata_s};
            cnt   <= cnt + 1'b1;
          end
          // the lead-in falling edge precedes bit 0, so it must not advance the response
          if (sclk_fall) begin
            lead_in <= 1'b0;
            if (!lead_in) begin
              tx_sr   <= {IDLE_SDATA, tx_sr[MAX_DATA_LENGTH-1:1]};
              sdata_o <= tx_sr[1];
            end
          end
          if (cs_rise) state <= ST_COMPLETE;
        end
        ST_COMPLETE: begin
          state   <= ST_IDLE;
          sdata_o <= IDLE_SDATA;
          if (cnt != '0 && !rxdata_valid_o) begin
            rxdata_o       <= rx_sr;
            rxdata_len_o   <= cnt;
            rxdata_valid_o <= 1'b1;
          end
`ifdef QUICK_SPI_RESPONDER_OVERRUN_EN
          if (cnt != '0 && rxdata_valid_o) rx_overrun_o <= 1'b1;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_quick_spi_responder.sv
// tb_quick_spi_responder: randomized scoreboard bench for quick_spi_responder.
module tb_quick_spi_responder;
  import quick_spi_pkg::*;
  localparam int   MAX  = 16;
  localparam int   LW   = len_width(MAX);
  localparam logic IDLE = 1'b0;
  localparam int   HALF = 4;
  logic clk = 0, rst = 1, tx_valid = 0, tx_ready, rx_valid, rx_ready = 1, underrun;
  logic sclk = 1, cs_n = 1, mosi = 0, miso;
  logic [MAX-1:0] tx_data = '0, rx_data;
  logic [LW-1:0] rx_len;
`ifdef QUICK_SPI_RESPONDER_OVERRUN_EN
  logic overrun;
`endif
  int vectors = 0, errors = 0;
  int underrun_cnt = 0, exp_underrun = 0;
  logic [MAX-1:0] exp_data_q[$];
  int exp_len_q[$];
  logic exp_miso_q[$];
  bit tx_full = 0;
  logic [MAX-1:0] tx_word = '0;
  always #5 clk = ~clk;
  quick_spi_responder dut (
    .clk_i(clk), .rst_i(rst),
    .txdata_valid_i(tx_valid), .txdata_ready_o(tx_ready), .txdata_i(tx_data),
    .rxdata_valid_o(rx_valid), .rxdata_ready_i(rx_ready), .rxdata_o(rx_data), .rxdata_len_o(rx_len),
    .tx_underrun_o(underrun),
    .sclk_i(sclk), .cs_n_i(cs_n), .sdata_i(mosi), .sdata_o(miso)
`ifdef QUICK_SPI_RESPONDER_OVERRUN_EN
    , .rx_overrun_o(overrun)
`endif
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // receive scoreboard: pop on every completed handshake
  always @(negedge clk)
    if (rx_valid && rx_ready) begin
      if (exp_data_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL rx_unexpected: got frame %0h len %0d, expected none", rx_data, rx_len);
      end else begin
        chk("rx_data", rx_data, exp_data_q.pop_front());
        chk("rx_len", rx_len, exp_len_q.pop_front());
      end
    end
  always @(negedge clk) if (underrun) underrun_cnt++;
  // response scoreboard: the controller samples sdata_o on each SCLK rise
  always @(posedge sclk)
    if (!cs_n) begin
      if (exp_miso_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL miso_unexpected: got %0b, expected no bit", miso);
      end else chk("miso", miso, exp_miso_q.pop_front());
    end
  task automatic load_tx(input logic [MAX-1:0] w);
    chk("tx_ready_before_load", tx_ready, !tx_full);
    tx_valid = 1;
    tx_data  = w;
    tick(1);
    tx_valid = 0;
    tx_full  = 1;
    tx_word  = w;
  endtask
  // n-bit frame, MSB of bits[n-1:0] first; only drive_n bits are clocked (drive_n < n aborts)
  task automatic frame(input int n, input logic [31:0] bits, input int drive_n);
    logic [MAX-1:0] resp;
    int len;
    resp = tx_full ? tx_word : {MAX{IDLE}};
    if (!tx_full) exp_underrun++;
    tx_full = 0;
    for (int i = 0; i < n; i++) exp_miso_q.push_back(i < MAX ? resp[i] : IDLE);
    cs_n = 0;
    tick(HALF);
    for (int i = 0; i < drive_n; i++) begin
      sclk = 0;
      mosi = bits[n-1-i];
      tick(HALF);
      sclk = 1;
      tick(HALF);
    end
    if (drive_n < n) return;
    if (n == 0) tick(HALF);
    len = n < MAX ? n : MAX;
    if (n > 0 && exp_data_q.size() == 0) begin
      exp_data_q.push_back(MAX'((bits >> (n - len)) & ((32'd1 << len) - 1)));
      exp_len_q.push_back(len);
    end
    cs_n = 1;
    tick(12);
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_rx_len"}, rx_len, 0);
    chk({tag, "_tx_ready"}, tx_ready, 1);
    chk({tag, "_underrun"}, underrun, 0);
    chk({tag, "_miso"}, miso, IDLE);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    tick(3);
    check_reset_outputs("reset");
    rst = 0;
    tick(6);
    // response and receive
    load_tx(16'h00A5);
    frame(8, 32'hC3, 8);
    chk("tx_ready_after_frame", tx_ready, !tx_full);
    // empty frame consumes the word, then an underrun frame follows
    load_tx(16'hBEEF);
    frame(0, 0, 0);
    chk("empty_no_rx", exp_data_q.size(), 0);
    chk("empty_tx_ready", tx_ready, !tx_full);
    frame(8, $urandom, 8);
    chk("underrun_pulses", underrun_cnt, exp_underrun);
    // long frame
    load_tx(16'h1357);
    frame(20, $urandom, 20);
    // back-pressure
    rx_ready = 0;
    frame(16, 32'h1234, 16);
    frame(16, 32'h5678, 16);
    chk("bp_valid", rx_valid, 1);
    chk("bp_hold_data", rx_data, 16'h1234);
    chk("bp_hold_len", rx_len, 16);
`ifdef QUICK_SPI_RESPONDER_OVERRUN_EN
    chk("bp_overrun", overrun, 1);
`endif
    rx_ready = 1;
    tick(4);
    chk("bp_drained", exp_data_q.size(), 0);
    // randomized frames
    for (int k = 0; k < 20; k++) begin
      int n;
      n = $urandom_range(1, 20);
      if ($urandom_range(0, 1) == 1) load_tx(MAX'($urandom));
      frame(n, $urandom, n);
    end
    // reset mid-frame with a held frame and a loaded word
    rx_ready = 0;
    frame(8, 32'h5A, 8);
    load_tx(16'hFFFF);
    frame(16, $urandom, 5);
    rst = 1;
    #1;
    check_reset_outputs("midrst");
    exp_miso_q.delete();
    exp_data_q.delete();
    exp_len_q.delete();
    tx_full = 0;
    cs_n = 1;
    mosi = 0;
    tick(3);
    rst = 0;
    rx_ready = 1;
    tick(6);
    underrun_cnt = 0;
    exp_underrun = 0;
    load_tx(MAX'($urandom));
    frame(16, $urandom, 16);
    tick(20);
    chk("rx_queue_drained", exp_data_q.size(), 0);
    chk("miso_queue_drained", exp_miso_q.size(), 0);
    chk("underrun_total", underrun_cnt, exp_underrun);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/quick_spi_responder.md
# quick_spi_responder

SPI responder (peripheral side): accepts SPI frames from an external controller whose bus protocol matches our SPI controller: SCLK idles high, data sampled on the rising edge, data changed on the falling edge, active-low chip select. Sits between the SPI pins and FPGA fabric. It presents each received frame on a valid/ready read port and serializes a preloaded response word back to the controller. All SPI inputs are asynchronous to `clk_i` and are synchronized internally.

## Interface
- `MAX_DATA_LENGTH`, 16, max bits per frame; received bits beyond this are discarded
- `SYNC_STAGES`, 2, flip-flop stages on each SPI input (≥2)
- `IDLE_SDATA`, 1'b0, value driven on `sdata_o` when no response bit is available
- `clk_i`  in  1  system clock
- `rst_i`  in  1  reset, asynchronous, active-high
- `txdata_valid_i`  in  1  response word offered
- `txdata_ready_o`  out  1  response buffer empty; load on valid&&ready
- `txdata_i`  in  MAX_DATA_LENGTH  response word, bit 0 sent first
- `rxdata_valid_o`  out  1  received frame available
- `rxdata_ready_i`  in  1  consumer accepts frame
- `rxdata_o`  out  MAX_DATA_LENGTH  received bits; first received bit at index `rxdata_len_o`-1, last at index 0
- `rxdata_len_o`  out  $clog2(MAX_DATA_LENGTH+1)  number of valid bits in `rxdata_o`
- `tx_underrun_o`  out  1  one-cycle pulse: frame started with response buffer empty
- `sclk_i`, `cs_n_i`, `sdata_i`  in  1 each  SPI pins (asynchronous)
- `sdata_o`  out  1  SPI response data

## Operation
- Reset (async assert, sync deassert inside the block): state IDLE. `txdata_ready_o`=1, `rxdata_valid_o`=0, `rxdata_o`=0, `rxdata_len_o`=0, `tx_underrun_o`=0, `sdata_o`=`IDLE_SDATA`. Synchronizers reset `cs_n` to 1 and `sclk` to 1.
- Edge detection on synchronized signals: `cs_fall`, `cs_rise`, `sclk_rise`, `sclk_fall`.
- States:
  - IDLE: on `cs_fall`, go to ACTIVE. Clear bit counter and rx shift register. If the tx buffer is full, move it into the tx shift register and set `txdata_ready_o`=1. Otherwise load `IDLE_SDATA` replicated and pulse `tx_underrun_o`. `sdata_o` = tx shift bit 0 from the following cycle.
  - ACTIVE, `sclk_rise`: shift `sdata_i` into bit 0 of rx register (shift left). Bit counter increments and saturates at MAX_DATA_LENGTH. At saturation further bits are ignored and the register is unchanged.
  - ACTIVE, `sclk_fall`: tx register shifts right, filling with `IDLE_SDATA`. The first `sclk_fall` of the frame (the controller's lead-in falling edge, before any rising edge) does not shift.
  - ACTIVE, `cs_rise`: go to COMPLETE.
  - COMPLETE (1 cycle): if count==0, discard and go to IDLE. If `rxdata_valid_o`==0, copy the rx register and count to the outputs, set `rxdata_valid_o`=1, and go to IDLE. Otherwise it is an overrun: the new frame is dropped, the held frame is kept, and the block goes to IDLE.
- `rxdata_valid_o` clears on valid&&ready. Outputs are stable while valid and not ready.
- A tx load and a `cs_fall` in the same cycle: the tx buffer is written first, so the new word is used for that frame.
- `cs_rise` and `sclk_rise` in the same cycle: the bit is sampled, then the state advances to COMPLETE.

## Timing
- Synchronizer latency is `SYNC_STAGES` cycles, plus 1 cycle for edge detection.
- SCLK high and low times must each be ≥ `SYNC_STAGES`+2 `clk_i` cycles. With the defaults, the SCLK frequency must be ≤ CLK/8.
- `sdata_o` updates `SYNC_STAGES`+2 cycles after the pin-level SCLK falling edge. It is valid before the next rising edge under the constraint above.
- `rxdata_valid_o` rises `SYNC_STAGES`+3 cycles after the pin-level `cs_n` rising edge.
- Minimum `cs_n` high time between frames is `SYNC_STAGES`+3 cycles.

## Configuration
- `QUICK_SPI_RESPONDER_OVERRUN_EN` defined:
  - adds output `rx_overrun_o` (1 bit), a sticky flag set on a COMPLETE-state overrun
  - cleared by reset or by the next rx handshake
- Not defined:
  - no port
  - overrun frames are silently dropped

## Structure
- Shared package `quick_spi_pkg`: the state encoding (IDLE/ACTIVE/COMPLETE) and the `clog2`-based length-width helper. These are shared with the controller.
- Sub-module `spi_input_sync` (parameterized depth, reset value), instantiated for `sclk_i`, `cs_n_i` and `sdata_i`.

## Test plan
- Response and receive:
  - Stimulus: load tx 16'h00A5, then drive an 8-bit frame with MOSI 8'b1100_0011 at CLK/8.
  - Required: `sdata_o` shows 1,0,1,0,0,1,0,1; `rxdata_o`=16'h00C3 and `rxdata_len_o`=8.
- Underrun:
  - Stimulus: a frame with the tx buffer empty.
  - Required: `tx_underrun_o` pulses once; `sdata_o`=`IDLE_SDATA` throughout.
- Long frame:
  - Stimulus: a 20-bit frame with MAX=16.
  - Required: `rxdata_len_o`=16, holding the first 16 bits.
- Back-pressure:
  - Stimulus: hold `rxdata_ready_i`=0 across two frames (0x1234, then 0x5678).
  - Required: output stays 0x1234; `rx_overrun_o`=1 when the macro is enabled.
- Empty frame:
  - Stimulus: `cs_n` pulses low with no SCLK edges.
  - Required: no `rxdata_valid_o`; the tx word is consumed.
- Reset mid-frame:
  - Stimulus: assert `rst_i` after 5 bits.
  - Required: all outputs return to reset values immediately; the next full frame is received correctly.
